// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 128-bit population-count encoder.
// Optional feature macro used by the block: ENCODER_FULL_FLAG_EN (adds out_full).
// Contents: widths, group geometry, saturation limit, saturating narrowing helper.
package encoder_pkg;

  localparam int IN_W     = 128;  // input vector width
  localparam int CNT_W    = 7;    // output count width
  localparam int GRP_W    = 8;    // bits covered by one partial count
  localparam int NUM_GRP  = 16;   // number of partial counts
  localparam int CNT_MAX  = 127;  // saturation value of out_count
  localparam int PART_W   = 4;    // width of one partial count (0..8)
  localparam int SUM_W    = 8;    // internal sum width, holds 0..128
  localparam int FULL_SUM = 128;  // sum value reached only by an all-ones input

  // Narrow the 8-bit sum to the 7-bit output, clamping 128 down to 127.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] sum);
    if (sum > SUM_W'(CNT_MAX)) begin
      return CNT_W'(CNT_MAX);
    end
    return sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/encoder_popcnt8.sv
// popcnt8: number of set bits in one 8-bit group, purely combinational.
// Ports: grp_i  - 8-bit group to count
//        cnt_o  - 4-bit count, 0..8
module popcnt8
  import encoder_pkg::*;
(
  input  logic [GRP_W-1:0]  grp_i,
  output logic [PART_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < GRP_W; i++) begin
      cnt_o = cnt_o + {{(PART_W-1){1'b0}}, grp_i[i]};
    end
  end

endmodule

// File: rtl/encoder.sv
// encoder: saturating population count of a 128-bit vector, 2-stage pipeline.
// Ports: clk, rst_n (async, active low), in_valid/in_data (input sample, no backpressure),
//        out_valid/out_count (result), out_full (only with ENCODER_FULL_FLAG_EN defined).
module encoder
  import encoder_pkg::*;
#(
  parameter int IN_W  = encoder_pkg::IN_W,
  parameter int CNT_W = encoder_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count
`ifdef ENCODER_FULL_FLAG_EN
  ,
  output logic             out_full
`endif
);

  // Only the packaged geometry is implemented; catch any other override at elaboration.
  if (IN_W != encoder_pkg::IN_W) begin : g_bad_in_w
    $error("encoder: IN_W must be 128");
  end
  if (CNT_W != encoder_pkg::CNT_W) begin : g_bad_cnt_w
    $error("encoder: CNT_W must be 7");
  end

  // ---------------- Stage 1: sixteen 8-bit partial counts ----------------
  logic [PART_W-1:0] part_d [NUM_GRP];
  logic [PART_W-1:0] part_q [NUM_GRP];
  logic              vld1_q;

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    popcnt8 u_popcnt8 (
      .grp_i (in_data[g*GRP_W +: GRP_W]),
      .cnt_o (part_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      for (int i = 0; i < NUM_GRP; i++) begin
        part_q[i] <= '0;
      end
    end else begin
      vld1_q <= in_valid;
      // Idle cycles leave the partial counts untouched.
      if (in_valid) begin
        for (int i = 0; i < NUM_GRP; i++) begin
          part_q[i] <= part_d[i];
        end
      end
    end
  end

  // ---------------- Stage 2: saturated sum ----------------
  logic [SUM_W-1:0] sum_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             vld2_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_GRP; i++) begin
      sum_d = sum_d + {{(SUM_W-PART_W){1'b0}}, part_q[i]};
    end
    cnt_d = sat_cnt(sum_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld2_q <= vld1_q;
      // The result only moves when a valid sample reaches the output stage.
      if (vld1_q) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign out_valid = vld2_q;
  assign out_count = cnt_q;

`ifdef ENCODER_FULL_FLAG_EN
  logic full_d;
  logic full_q;

  // A sum of 128 is only reachable when every input bit is set.
  assign full_d = (sum_d == SUM_W'(FULL_SUM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (vld1_q) begin
      full_q <= full_d;
    end
  end

  assign out_full = full_q;
`endif

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed scoreboard bench for the population-count encoder.
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
// Checks count, exact 2-cycle latency, hold behaviour, async reset and flag (if built).
module tb_encoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_valid;
  logic [6:0]   out_count;
`ifdef ENCODER_FULL_FLAG_EN
  logic         out_full;
`endif

  encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_count (out_count)
`ifdef ENCODER_FULL_FLAG_EN
    ,
    .out_full  (out_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cnt;
    logic       full;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("stale_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_count", 32'(out_count), 32'(e.cnt));
        check("latency_cycle", 32'(cyc), 32'(e.due));
`ifdef ENCODER_FULL_FLAG_EN
        check("out_full", 32'(out_full), 32'(e.full));
`endif
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check("missing_out_valid", 32'(out_valid), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic send(input logic [127:0] d, input logic [6:0] cnt, input logic full);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back('{cnt: cnt, full: full, due: cyc + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  logic [127:0] ones;
  logic [127:0] top_bit;

  initial begin
    ones     = '1;
    top_bit  = '0;
    top_bit[127] = 1'b1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
`ifdef ENCODER_FULL_FLAG_EN
    check("reset_out_full", 32'(out_full), 32'd0);
`endif
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Isolated directed vectors.
    send(128'h0, 7'd0, 1'b0);                       idle(3);
    send(128'h1, 7'd1, 1'b0);                       idle(3);
    send(128'h9D5, 7'd7, 1'b0);                     idle(3);
    send(128'h5555_5555_5555_5555, 7'd32, 1'b0);    idle(3);
    send(top_bit, 7'd1, 1'b0);                      idle(3);
    send(ones ^ 128'h1, 7'd127, 1'b0);              idle(3);
    send(ones, 7'd127, 1'b1);                       idle(3);

    // Back-to-back stream.
    send(128'h0, 7'd0, 1'b0);
    send(128'h1, 7'd1, 1'b0);
    send(128'h9D5, 7'd7, 1'b0);
    idle(4);

    // Outputs hold the last result while idle.
    check("hold_out_valid", 32'(out_valid), 32'd0);
    check("hold_out_count", 32'(out_count), 32'd7);

    // Reset mid-stream: first result is on the outputs, second still in flight.
    send(128'h5555_5555_5555_5555, 7'd32, 1'b0);
    send(ones, 7'd127, 1'b1);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("pre_reset_out_count", 32'(out_count), 32'd32);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_out_count", 32'(out_count), 32'd0);
`ifdef ENCODER_FULL_FLAG_EN
    check("async_reset_out_full", 32'(out_full), 32'd0);
`endif
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("post_reset_out_count", 32'(out_count), 32'd0);

    // First input after reset arrives with normal latency.
    send(128'h9D5, 7'd7, 1'b0);
    idle(4);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
